wait_state_memory: RTL and testbench
====================================

// Module: wait_state_memory
// PURPOSE
//  Clocked, parametrised single-port main memory for the multicycle datapath; replaces level-triggered async access.
//  Valid/ready request channel, programmable wait states, one-cycle response pulse, out-of-range error flag.
//  Sits between the control unit's memory-cycle states and the shared instruction/data store.
// PARAMETERS
//  DATA_W    12    word width (bits)
//  ADDR_W    12    address width (bits)
//  DEPTH     4096  implemented words; DEPTH <= 2**ADDR_W
//  WAIT_CYC  2     wait-state cycles before array access; 0 legal
//  INIT_FILE ""    hex image loaded once at elaboration via $readmemh; "" = no preload
// PORTS
//  clk        in   1       single clock, all logic on rising edge
//  rst        in   1       synchronous, active-high reset
//  req_valid  in   1       request present
//  req_ready  out  1       block can accept request (IDLE only)
//  req_write  in   1       1 = write, 0 = read
//  req_inc    in   1       increment-and-write-back op (see CONFIGURATION)
//  req_addr   in   ADDR_W  word address
//  req_wdata  in   DATA_W  write data
//  rsp_valid  out  1       one-cycle completion pulse
//  rsp_rdata  out  DATA_W  read data / written data / incremented value
//  rsp_err    out  1       address >= DEPTH; valid with rsp_valid
//  rsp_zero   out  1       incremented result == 0; valid with rsp_valid
// BEHAVIOUR
//  Reset values: req_ready=0 while rst high, 1 first cycle after; rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_zero=0.
//  Array contents never cleared by rst.
//  FSM: IDLE -> WAIT -> ACCESS -> [WB] -> RESP -> IDLE.
//   IDLE: req_ready=1; accept on req_valid&&req_ready; capture write/inc/addr/wdata; counter=WAIT_CYC.
//   IDLE exit: WAIT if WAIT_CYC>0, else ACCESS.
//   WAIT: counter decrements each cycle; at 1 -> ACCESS.
//   ACCESS: read: rsp_rdata <= mem[addr]; write: mem[addr] <= wdata, rsp_rdata <= wdata; -> RESP (WB if inc).
//   RESP: rsp_valid=1 exactly one cycle; -> IDLE. rsp_rdata/err/zero hold until next RESP.
//  Latency: accept edge = edge 0; rsp_valid high in cycle after edge WAIT_CYC+1 (+1 for inc).
//  req_ready=0 in every state except IDLE; no back-to-back; one access per WAIT_CYC+3 cycles.
//  Captured request is immune to input changes after accept.
//  Out of range (addr >= DEPTH): no array read/write; rsp_rdata=0, rsp_err=1, normal latency.
//  Both req_write and req_inc set: req_write wins.
//  rst in any state: -> IDLE next edge; pending op dropped; write lands only if its ACCESS edge already passed.
// CONFIGURATION
//  Macro MEM_RMW_INC_EN.
//  Defined: req_inc=1 read request is read-modify-write; ACCESS reads; WB writes mem[addr] <= (val+1) mod 2**DATA_W.
//   rsp_rdata = incremented value; rsp_zero = (result==0). One extra cycle latency.
//  Undefined: WB state absent; req_inc ignored (plain read); rsp_zero tied 0. Port list identical.
// STRUCTURE
//  Package mem_pkg: mem_state_t enum (IDLE, WAIT, ACCESS, WB, RESP); mem_op_t (OP_RD, OP_WR, OP_INC);
//   default width constants DATA_W_DEF=12, ADDR_W_DEF=12.
//  Sub-module sp_ram_array: synchronous single-port array, we/addr/wdata/rdata, INIT_FILE preload.
//  Top holds FSM, wait counter, request capture, range check, incrementer.
// TESTING (DATA_W=12, ADDR_W=12, DEPTH=4096, WAIT_CYC=2 unless noted)
//  1 Write 12'h3E8 to addr 40, then read 40 -> rsp_rdata=12'h3E8, rsp_err=0; rsp_valid 1 cycle, 3 edges after accept.
//  2 req_valid held through busy; 2nd req accepted only after RESP -> req_ready 0 during WAIT/ACCESS/RESP.
//  3 DEPTH=1000, read addr 1000 -> rsp_err=1, rsp_rdata=0; write addr 1005 leaves mem[5] unchanged.
//  4 MEM_RMW_INC_EN, mem[43]=12'hFF6 (-10): ten inc ops -> rsp_zero=1 only on 10th, rsp_rdata=0.
//  5 rst asserted in WAIT of write to addr 7 (old 12'h055) -> IDLE next edge, no rsp_valid, mem[7]=12'h055.
//  6 WAIT_CYC=0, read -> rsp_valid 1 edge after accept; WAIT state never entered.

Source files
------------

// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared types and default widths for the wait-state main memory.
//   mem_state_t : control FSM states (IDLE, WAIT, ACCESS, WB, RESP)
//   mem_op_t    : operation captured when a request is accepted
//   DATA_W_DEF / ADDR_W_DEF : default word and address widths
// -----------------------------------------------------------------------------
package mem_pkg;

    localparam int DATA_W_DEF = 12;
    localparam int ADDR_W_DEF = 12;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        ACCESS,
        WB,
        RESP
    } mem_state_t;

    typedef enum logic [1:0] {
        OP_RD,
        OP_WR,
        OP_INC
    } mem_op_t;

endpackage

// File: rtl/sp_ram_array.sv
// -----------------------------------------------------------------------------
// sp_ram_array
// Synchronous single-port word array. One write and one registered read per
// clock; a read on the same edge as a write returns the old word.
// Ports:
//   clk   in  1       rising-edge clock
//   we    in  1       write enable
//   addr  in  ADDR_W  word address (caller guarantees addr < DEPTH)
//   wdata in  DATA_W  write data
//   rdata out DATA_W  registered read data, mem[addr] from the previous edge
// -----------------------------------------------------------------------------
module sp_ram_array #(
    parameter int DATA_W    = 12,
    parameter int ADDR_W    = 12,
    parameter int DEPTH     = 4096,
    parameter     INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]  idx;
    logic              unused_addr;

    assign idx         = addr[IDX_W-1:0];
    // Upper address bits only matter to the caller's range check.
    assign unused_addr = ^addr;

    // NOTE: the array has no reset branch on purpose -- contents survive reset
    // and a resettable array could not map onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        rdata <= mem[idx];
    end

endmodule

// File: rtl/wait_state_memory.sv
// -----------------------------------------------------------------------------
// wait_state_memory
// Clocked single-port main memory for the multicycle datapath. A request is
// accepted in IDLE, waits WAIT_CYC cycles, touches the array in ACCESS and
// reports completion with a one-cycle rsp_valid pulse in RESP.
// Optional feature macro: MEM_RMW_INC_EN -- a read with req_inc set becomes a
// read-modify-write increment (extra WB cycle). Without it req_inc is ignored
// and rsp_zero is tied low.
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   req_valid / req_ready    request handshake; ready only in IDLE
//   req_write, req_inc       operation select (write wins over inc)
//   req_addr, req_wdata      word address and write data
//   rsp_valid                one-cycle completion pulse
//   rsp_rdata                read data / written data / incremented value
//   rsp_err                  address was >= DEPTH (no array access)
//   rsp_zero                 incremented result was zero
// -----------------------------------------------------------------------------
module wait_state_memory
    import mem_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DEPTH     = 4096,
    parameter int WAIT_CYC  = 2,
    parameter     INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_inc,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_zero
);

    localparam int CNT_W = (WAIT_CYC > 0) ? $clog2(WAIT_CYC + 1) : 1;

    mem_state_t        state;
    mem_op_t           op_q;
    mem_op_t           op_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              err_q;
    logic              req_in_range;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    // Ready is low for the whole time rst is held, then high as soon as the
    // FSM sits in IDLE.
    assign req_ready    = (state == IDLE) && !rst;
    // Extra MSB so DEPTH == 2**ADDR_W compares correctly.
    assign req_in_range = {1'b0, req_addr} < (ADDR_W + 1)'(DEPTH);

`ifdef MEM_RMW_INC_EN
    logic [DATA_W-1:0] inc_val;
    logic              zero_q;

    assign inc_val  = ram_rdata + DATA_W'(1);
    assign rsp_zero = zero_q;
    assign op_d     = req_write ? OP_WR : (req_inc ? OP_INC : OP_RD);
`else
    logic unused_inc;

    assign unused_inc = req_inc;
    assign rsp_zero   = 1'b0;
    assign op_d       = req_write ? OP_WR : OP_RD;
`endif

    // The array address follows the live request while idle so the registered
    // read is already valid when ACCESS is reached, even with WAIT_CYC = 0.
    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = (state == IDLE) ? req_addr : addr_q;
        ram_wdata = wdata_q;
        if (!rst && !err_q) begin
            if (state == ACCESS && op_q == OP_WR) begin
                ram_we = 1'b1;
            end
`ifdef MEM_RMW_INC_EN
            if (state == WB) begin
                ram_we    = 1'b1;
                ram_wdata = inc_val;
            end
`endif
        end
    end

    sp_ram_array #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .INIT_FILE(INIT_FILE)
    ) u_array (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
`ifdef MEM_RMW_INC_EN
            zero_q    <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q    <= op_d;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        err_q   <= !req_in_range;
                        cnt_q   <= CNT_W'(WAIT_CYC);
                        state   <= (WAIT_CYC > 0) ? WAIT : ACCESS;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
`ifdef MEM_RMW_INC_EN
                    if (op_q == OP_INC) begin
                        state <= WB;
                    end else begin
                        zero_q <= 1'b0;
`else
                    begin
`endif
                        rsp_valid <= 1'b1;
                        rsp_err   <= err_q;
                        if (err_q) begin
                            rsp_rdata <= '0;
                        end else if (op_q == OP_WR) begin
                            rsp_rdata <= wdata_q;
                        end else begin
                            rsp_rdata <= ram_rdata;
                        end
                        state <= RESP;
                    end
                end
`ifdef MEM_RMW_INC_EN
                WB: begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= err_q;
                    rsp_rdata <= err_q ? '0 : inc_val;
                    zero_q    <= !err_q && (inc_val == '0);
                    state     <= RESP;
                end
`endif
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wait_state_memory.sv
// -----------------------------------------------------------------------------
// tb_wait_state_memory
// Three instances share one request bus: u0 (DEPTH 4096, WAIT_CYC 2),
// u1 (DEPTH 1000, WAIT_CYC 2) and u2 (DEPTH 4096, WAIT_CYC 0). Outputs are
// sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_wait_state_memory;

    localparam int DW = 12;
    localparam int AW = 12;
    localparam int N  = 3;
`ifdef MEM_RMW_INC_EN
    localparam int INC_X = 1;
`else
    localparam int INC_X = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_write = 1'b0;
    logic          req_inc = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;

    logic [N-1:0]  ready;
    logic [N-1:0]  vld;
    logic [N-1:0]  err;
    logic [N-1:0]  zero;
    logic [DW-1:0] rdata [N];

    int            lat    [N];
    int            pulses [N];
    int            lowrdy [N];
    logic [DW-1:0] got_d  [N];
    logic          got_e  [N];
    logic          got_z  [N];
    int            base_lat [N] = '{3, 3, 1};

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    wait_state_memory #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(4096), .WAIT_CYC(2)) u0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready[0]),
        .req_write(req_write), .req_inc(req_inc), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(vld[0]), .rsp_rdata(rdata[0]),
        .rsp_err(err[0]), .rsp_zero(zero[0])
    );

    wait_state_memory #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(1000), .WAIT_CYC(2)) u1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready[1]),
        .req_write(req_write), .req_inc(req_inc), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(vld[1]), .rsp_rdata(rdata[1]),
        .rsp_err(err[1]), .rsp_zero(zero[1])
    );

    wait_state_memory #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(4096), .WAIT_CYC(0)) u2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready[2]),
        .req_write(req_write), .req_inc(req_inc), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(vld[2]), .rsp_rdata(rdata[2]),
        .rsp_err(err[2]), .rsp_zero(zero[2])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Leaves the bench on a falling edge with every instance idle.
    task automatic wait_idle();
        int n = 0;
        while (ready !== 3'b111 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", 32'(ready), 32'h7);
    endtask

    // One request, held for exactly the accept edge, then the inputs are
    // scrambled to show the captured request is unaffected.
    task automatic run_req(input logic w, input logic inc, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input int ncyc);
        wait_idle();
        req_valid = 1'b1;
        req_write = w;
        req_inc   = inc;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_write = ~w;
        req_inc   = ~inc;
        req_addr  = ~a;
        req_wdata = ~d;
        for (int k = 0; k < N; k++) begin
            lat[k] = -1; pulses[k] = 0; lowrdy[k] = 0;
            got_d[k] = '0; got_e[k] = 1'b0; got_z[k] = 1'b0;
        end
        for (int c = 0; c <= ncyc; c++) begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                if (!ready[k]) lowrdy[k]++;
                if (vld[k]) begin
                    pulses[k]++;
                    if (lat[k] < 0) begin
                        lat[k]   = c;
                        got_d[k] = rdata[k];
                        got_e[k] = err[k];
                        got_z[k] = zero[k];
                    end
                end
            end
        end
    endtask

    task automatic check_rsp(input string tag, input int k, input int elat,
                             input logic [DW-1:0] ed, input logic ee, input logic ez);
        check($sformatf("%s_u%0d_lat", tag, k), lat[k], elat);
        check($sformatf("%s_u%0d_pulses", tag, k), pulses[k], 1);
        check($sformatf("%s_u%0d_rdata", tag, k), 32'(got_d[k]), 32'(ed));
        check($sformatf("%s_u%0d_err", tag, k), 32'(got_e[k]), 32'(ee));
        check($sformatf("%s_u%0d_zero", tag, k), 32'(got_z[k]), 32'(ez));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int first, second, np, low;
        logic rdy4;
        logic [DW-1:0] ed;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(ready), 32'h0);
        check("rst_valid", 32'(vld), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_zero", 32'(zero), 32'h0);
        for (int k = 0; k < N; k++) check($sformatf("rst_rdata_u%0d", k), 32'(rdata[k]), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(ready), 32'h7);

        // Write then read back addr 40
        run_req(1'b1, 1'b0, 12'd40, 12'h3E8, 8);
        for (int k = 0; k < N; k++) check_rsp("wr40", k, base_lat[k], 12'h3E8, 1'b0, 1'b0);
        check("wr40_u0_ready_low", lowrdy[0], 4);
        check("wr40_u2_ready_low", lowrdy[2], 2);
        run_req(1'b0, 1'b0, 12'd40, 12'h000, 8);
        for (int k = 0; k < N; k++) check_rsp("rd40", k, base_lat[k], 12'h3E8, 1'b0, 1'b0);

        // req_valid held through the busy period: no back-to-back accept
        wait_idle();
        req_valid = 1'b1; req_write = 1'b0; req_inc = 1'b0; req_addr = 12'd40;
        first = -1; second = -1; np = 0; low = 0; rdy4 = 1'b0;
        for (int c = 0; c <= 12; c++) begin
            @(negedge clk);
            if (!ready[0]) low++;
            if (c == 4) rdy4 = ready[0];
            if (vld[0]) begin
                np++;
                if (first < 0) first = c; else second = c;
            end
            if (c == 5) req_valid = 1'b0;
        end
        check("held_first_rsp", first, 3);
        check("held_second_rsp", second, 8);
        check("held_pulses", np, 2);
        check("held_ready_low", low, 8);
        check("held_ready_in_idle", 32'(rdy4), 32'h1);
        check("held_rdata", 32'(rdata[0]), 32'h3E8);

        // Out-of-range handling on the DEPTH=1000 instance
        run_req(1'b1, 1'b0, 12'd1000, 12'h123, 8);
        for (int k = 0; k < N; k++)
            check_rsp("wr1000", k, base_lat[k], (k == 1) ? 12'h000 : 12'h123, k == 1, 1'b0);
        run_req(1'b0, 1'b0, 12'd1000, 12'h000, 8);
        for (int k = 0; k < N; k++)
            check_rsp("rd1000", k, base_lat[k], (k == 1) ? 12'h000 : 12'h123, k == 1, 1'b0);
        run_req(1'b1, 1'b0, 12'd5, 12'h0A5, 8);
        run_req(1'b1, 1'b0, 12'd1005, 12'h777, 8);
        for (int k = 0; k < N; k++)
            check_rsp("wr1005", k, base_lat[k], (k == 1) ? 12'h000 : 12'h777, k == 1, 1'b0);
        run_req(1'b0, 1'b0, 12'd5, 12'h000, 8);
        for (int k = 0; k < N; k++) check_rsp("rd5", k, base_lat[k], 12'h0A5, 1'b0, 1'b0);

        // Increment sequence from -10 at addr 43
        run_req(1'b1, 1'b0, 12'd43, 12'hFF6, 8);
        for (int i = 1; i <= 10; i++) begin
            run_req(1'b0, 1'b1, 12'd43, 12'h000, 9);
            ed = (INC_X == 1) ? 12'hFF6 + DW'(i) : 12'hFF6;
            for (int k = 0; k < N; k++)
                check_rsp($sformatf("inc%0d", i), k, base_lat[k] + INC_X, ed, 1'b0,
                          (INC_X == 1) && (ed == 12'h000));
        end
        run_req(1'b0, 1'b0, 12'd43, 12'h000, 8);
        for (int k = 0; k < N; k++)
            check_rsp("rd43", k, base_lat[k], (INC_X == 1) ? 12'h000 : 12'hFF6, 1'b0, 1'b0);

        // Write and inc together: write wins
        run_req(1'b1, 1'b1, 12'd44, 12'h5A5, 9);
        for (int k = 0; k < N; k++) check_rsp("wrinc44", k, base_lat[k], 12'h5A5, 1'b0, 1'b0);

        // Reset during WAIT of a write to addr 7
        run_req(1'b1, 1'b0, 12'd7, 12'h055, 8);
        wait_idle();
        req_valid = 1'b1; req_write = 1'b1; req_inc = 1'b0; req_addr = 12'd7; req_wdata = 12'hABC;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_write = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_wait_u0_no_rsp", 32'(vld[0]), 32'h0);
        check("rst_wait_u2_rsp", 32'(vld[2]), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_wait_ready", 32'(ready), 32'h0);
        check("rst_wait_valid", 32'(vld), 32'h0);
        rst = 1'b0;
        np = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (vld != '0) np++;
        end
        check("rst_wait_no_late_rsp", np, 0);
        run_req(1'b0, 1'b0, 12'd7, 12'h000, 8);
        for (int k = 0; k < N; k++)
            check_rsp("rd7", k, base_lat[k], (k == 2) ? 12'hABC : 12'h055, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
